// File: rtl/layer_mixer_pkg.sv
// Shared layer geometry, colour-key and flash constants for the figure
// compositor, plus the 11-bit span test used for region checks.
package layer_mixer_pkg;

    // Figure sprite placement on the 640x480 raster
    localparam logic [9:0] FIG_X_START   = 10'd200;
    localparam logic [9:0] FIG_X_SIZE    = 10'd64;
    localparam logic [9:0] FIG_Y_START_F = 10'd300;
    localparam logic [9:0] FIG_Y_START_H = 10'd100;
    localparam logic [9:0] FIG_Y_SIZE    = 10'd96;

    // Palette index 0 of the figure layer is transparent
    localparam logic [11:0] KEY_COLOR_FIG = 12'hFDD;

    // Layer pipeline depth and hit-flash timing, shared with other layers
    localparam int LAYER_LAT_FIG    = 2;
    localparam int FLASH_FRAMES_FIG = 32;
    localparam int FLASH_HALF_FIG   = 4;

    // Flash state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    // True when start <= v < start + size; widened so the sum cannot wrap
    function automatic logic in_span(input logic [9:0] v,
                                     input logic [9:0] start,
                                     input logic [9:0] size);
        logic [10:0] val_w;
        logic [10:0] lo_w;
        logic [10:0] hi_w;
        val_w = {1'b0, v};
        lo_w  = {1'b0, start};
        hi_w  = lo_w + {1'b0, size};
        return (val_w >= lo_w) && (val_w < hi_w);
    endfunction

endpackage

// File: rtl/layer_mixer_delay_line.sv
// Fixed-depth shift register with synchronous reset; keeps side-band
// pixel attributes aligned with the latency of a colour layer.
module delay_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             pixel_clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift one stage per pixel clock; reset flushes every stage to zero
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/layer_mixer.sv
// Figure/background compositor: aligns the figure region test with the
// layer latency, applies colour-key transparency and a frame-counted hit
// flash, and drives registered, blank-gated 4-bit RGB.
module layer_mixer
    import layer_mixer_pkg::*;
#(
    parameter int          LAYER_LAT    = LAYER_LAT_FIG,
    parameter logic [11:0] KEY_COLOR    = KEY_COLOR_FIG,
    parameter int          FLASH_FRAMES = FLASH_FRAMES_FIG,
    parameter int          FLASH_HALF   = FLASH_HALF_FIG
) (
    input  logic        pixel_clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        pos_select,
    input  logic        fig_enable,
    input  logic        hit,
    input  logic [11:0] fig_color,
    input  logic [11:0] bg_color,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        blank_out,
    output logic        flashing
);

    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int PW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [FW-1:0] CNT_LOAD = FW'(FLASH_FRAMES);
    localparam logic [FW-1:0] CNT_ONE  = FW'(1);
    localparam logic [PW-1:0] PH_LAST  = PW'(FLASH_HALF - 1);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);

    logic [9:0]    anchor_y_s;
    logic          in_fig_s;
    logic          at_origin_s;
    logic          at_origin_r;
    logic          frame_tick_s;
    logic [1:0]    align_in_s;
    logic [1:0]    align_out_s;
    logic          fig_aligned_s;
    logic          blank_aligned_s;
    logic [11:0]   pix_s;

    logic [0:0]    state_r;
    logic [0:0]    state_nx_s;
    logic [FW-1:0] flash_cnt_r;
    logic [FW-1:0] flash_cnt_nx_s;
    logic [PW-1:0] phase_cnt_r;
    logic [PW-1:0] phase_cnt_nx_s;
    logic          flash_on_r;
    logic          flash_on_nx_s;

    // Stage-0 figure region test against the selected vertical anchor
    always_comb begin
        anchor_y_s = FIG_Y_START_H;
        if (pos_select) begin
            anchor_y_s = FIG_Y_START_F;
        end else begin
            anchor_y_s = FIG_Y_START_H;
        end
        in_fig_s = fig_enable
                 && in_span(DrawX, FIG_X_START, FIG_X_SIZE)
                 && in_span(DrawY, anchor_y_s, FIG_Y_SIZE);
    end

    // Frame tick fires on the first cycle at the origin so a held origin
    // pixel cannot produce more than one tick per frame
    assign at_origin_s  = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign frame_tick_s = at_origin_s && !at_origin_r;

    // Remember whether the previous pixel was the origin
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            at_origin_r <= 1'b0;
        end else begin
            at_origin_r <= at_origin_s;
        end
    end

    assign align_in_s = {in_fig_s, blank};

    delay_line #(
        .WIDTH (2),
        .DEPTH (LAYER_LAT)
    ) u_align (
        .pixel_clk (pixel_clk),
        .Reset     (Reset),
        .d         (align_in_s),
        .q         (align_out_s)
    );

    assign fig_aligned_s   = align_out_s[1];
    assign blank_aligned_s = align_out_s[0];

    // Flash next-state: a hit always reloads; ticks count down and pace the blink
    always_comb begin
        state_nx_s     = state_r;
        flash_cnt_nx_s = flash_cnt_r;
        phase_cnt_nx_s = phase_cnt_r;
        flash_on_nx_s  = flash_on_r;
        case (state_r)
            ST_IDLE: begin
                if (hit) begin
                    state_nx_s     = ST_FLASH;
                    flash_cnt_nx_s = CNT_LOAD;
                    phase_cnt_nx_s = {PW{1'b0}};
                    flash_on_nx_s  = 1'b1;
                end else begin
                    state_nx_s     = ST_IDLE;
                end
            end
            ST_FLASH: begin
                if (hit) begin
                    flash_cnt_nx_s = CNT_LOAD;
                    phase_cnt_nx_s = {PW{1'b0}};
                    flash_on_nx_s  = 1'b1;
                end else if (frame_tick_s) begin
                    if (flash_cnt_r == CNT_ONE) begin
                        state_nx_s     = ST_IDLE;
                        flash_cnt_nx_s = {FW{1'b0}};
                        phase_cnt_nx_s = {PW{1'b0}};
                        flash_on_nx_s  = 1'b0;
                    end else begin
                        flash_cnt_nx_s = flash_cnt_r - CNT_ONE;
                        if (phase_cnt_r == PH_LAST) begin
                            phase_cnt_nx_s = {PW{1'b0}};
                            flash_on_nx_s  = ~flash_on_r;
                        end else begin
                            phase_cnt_nx_s = phase_cnt_r + PH_ONE;
                        end
                    end
                end else begin
                    state_nx_s = ST_FLASH;
                end
            end
            default: begin
                state_nx_s     = ST_IDLE;
                flash_cnt_nx_s = {FW{1'b0}};
                phase_cnt_nx_s = {PW{1'b0}};
                flash_on_nx_s  = 1'b0;
            end
        endcase
    end

    // Flash state registers; flashing mirrors the registered state
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            flash_cnt_r <= {FW{1'b0}};
            phase_cnt_r <= {PW{1'b0}};
            flash_on_r  <= 1'b0;
            flashing    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            flash_cnt_r <= flash_cnt_nx_s;
            phase_cnt_r <= phase_cnt_nx_s;
            flash_on_r  <= flash_on_nx_s;
            flashing    <= (state_nx_s == ST_FLASH);
        end
    end

    // Pixel selection: blanking, then opaque figure (white while flashing), then background
    always_comb begin
        pix_s = 12'h000;
        if (!blank_aligned_s) begin
            pix_s = 12'h000;
        end else if (fig_aligned_s && (fig_color != KEY_COLOR)) begin
            if (flash_on_r) begin
                pix_s = 12'hFFF;
            end else begin
                pix_s = fig_color;
            end
        end else begin
            pix_s = bg_color;
        end
    end

    // Registered VGA outputs with matching delayed blank
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            Red       <= 4'h0;
            Green     <= 4'h0;
            Blue      <= 4'h0;
            blank_out <= 1'b0;
        end else begin
            Red       <= pix_s[11:8];
            Green     <= pix_s[7:4];
            Blue      <= pix_s[3:0];
            blank_out <= blank_aligned_s;
        end
    end

endmodule

// File: tb/tb_layer_mixer.sv
// Directed self-checking bench for layer_mixer.
module tb_layer_mixer;

    logic        pixel_clk;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        pos_select;
    logic        fig_enable;
    logic        hit;
    logic [11:0] fig_color;
    logic [11:0] bg_color;
    logic [3:0]  Red;
    logic [3:0]  Green;
    logic [3:0]  Blue;
    logic        blank_out;
    logic        flashing;
    logic [11:0] rgb_s;

    int total;
    int bad;

    layer_mixer dut (
        .pixel_clk  (pixel_clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .pos_select (pos_select),
        .fig_enable (fig_enable),
        .hit        (hit),
        .fig_color  (fig_color),
        .bg_color   (bg_color),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .blank_out  (blank_out),
        .flashing   (flashing)
    );

    assign rgb_s = {Red, Green, Blue};

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic set_px(input logic [9:0] x, input logic [9:0] y, input logic b);
        DrawX = x;
        DrawY = y;
        blank = b;
    endtask

    task automatic hold3(input logic [9:0] x, input logic [9:0] y);
        set_px(x, y, 1'b1);
        tick();
        tick();
        tick();
    endtask

    // One frame: origin pixel (tick), then figure pixels until the output settles
    task automatic frame_tick(input logic with_hit);
        set_px(10'd0, 10'd0, 1'b1);
        hit = with_hit;
        tick();
        hit = 1'b0;
        hold3(10'd220, 10'd120);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        set_px(10'd220, 10'd120, 1'b1);
        tick();
        tick();
        total++;
        if (rgb_s !== 12'h000) begin
            bad++;
            $display("FAIL reset_rgb: got %h want %h", rgb_s, 12'h000);
        end
        total++;
        if (blank_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_blank_out: got %b want 0", blank_out);
        end
        total++;
        if (flashing !== 1'b0) begin
            bad++;
            $display("FAIL reset_flashing: got %b want 0", flashing);
        end
        Reset = 1'b0;
    endtask

    task automatic test_region();
        logic [9:0]  xs  [9];
        logic [9:0]  ys  [9];
        logic [11:0] exp [9];
        xs  = '{10'd199, 10'd200, 10'd199, 10'd200, 10'd263, 10'd264, 10'd220, 10'd220, 10'd220};
        ys  = '{10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd100, 10'd99,  10'd195, 10'd196};
        exp = '{12'h0F0, 12'h123, 12'h0F0, 12'h123, 12'h123, 12'h0F0, 12'h0F0, 12'h123, 12'h0F0};
        pos_select = 1'b0;
        fig_enable = 1'b1;
        fig_color  = 12'h123;
        bg_color   = 12'h0F0;
        hold3(10'd300, 10'd100);
        for (int i = 0; i < 11; i++) begin
            if (i < 9) set_px(xs[i], ys[i], 1'b1);
            else       set_px(10'd300, 10'd100, 1'b1);
            tick();
            if (i >= 2) begin
                total++;
                if (rgb_s !== exp[i-2]) begin
                    bad++;
                    $display("FAIL region[%0d]: got %h want %h", i - 2, rgb_s, exp[i-2]);
                end
            end
        end
    endtask

    task automatic test_transparency();
        fig_color = 12'hFDD;
        bg_color  = 12'h00F;
        hold3(10'd220, 10'd120);
        tick();
        total++;
        if (rgb_s !== 12'h00F) begin
            bad++;
            $display("FAIL transparency: got %h want %h", rgb_s, 12'h00F);
        end
    endtask

    task automatic test_blanking();
        logic        bs   [4];
        logic [11:0] exp  [4];
        bs  = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp = '{12'h123, 12'h000, 12'h123, 12'h123};
        fig_color = 12'h123;
        bg_color  = 12'h0F0;
        hold3(10'd220, 10'd120);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_px(10'd220, 10'd120, bs[i]);
            else       set_px(10'd220, 10'd120, 1'b1);
            tick();
            if (i >= 2) begin
                total++;
                if (rgb_s !== exp[i-2]) begin
                    bad++;
                    $display("FAIL blank_rgb[%0d]: got %h want %h", i - 2, rgb_s, exp[i-2]);
                end
                total++;
                if (blank_out !== bs[i-2]) begin
                    bad++;
                    $display("FAIL blank_out[%0d]: got %b want %b", i - 2, blank_out, bs[i-2]);
                end
            end
        end
    endtask

    task automatic test_anchor();
        logic        sel [6];
        logic        en  [6];
        logic [9:0]  ys  [6];
        logic [11:0] exp [6];
        sel = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ys  = '{10'd100, 10'd300, 10'd395, 10'd396, 10'd300, 10'd100};
        exp = '{12'h0F0, 12'h123, 12'h123, 12'h0F0, 12'h0F0, 12'h0F0};
        fig_color = 12'h123;
        bg_color  = 12'h0F0;
        for (int i = 0; i < 6; i++) begin
            pos_select = sel[i];
            fig_enable = en[i];
            hold3(10'd220, ys[i]);
            total++;
            if (rgb_s !== exp[i]) begin
                bad++;
                $display("FAIL anchor[%0d]: got %h want %h", i, rgb_s, exp[i]);
            end
        end
        pos_select = 1'b0;
        fig_enable = 1'b1;
    endtask

    task automatic test_flash();
        logic [11:0] exp_c;
        logic        exp_f;
        fig_color = 12'h123;
        bg_color  = 12'h0F0;
        set_px(10'd220, 10'd120, 1'b1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        hold3(10'd220, 10'd120);
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) frame_tick(1'b0);
            exp_f = (k < 32);
            exp_c = (exp_f && ((k / 4) % 2 == 0)) ? 12'hFFF : 12'h123;
            total++;
            if (rgb_s !== exp_c) begin
                bad++;
                $display("FAIL flash_rgb[frame %0d]: got %h want %h", k, rgb_s, exp_c);
            end
            total++;
            if (flashing !== exp_f) begin
                bad++;
                $display("FAIL flash_active[frame %0d]: got %b want %b", k, flashing, exp_f);
            end
        end
    endtask

    task automatic test_restart();
        logic [11:0] exp_c;
        logic        exp_f;
        int          r;
        set_px(10'd220, 10'd120, 1'b1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        hold3(10'd220, 10'd120);
        for (int k = 1; k <= 10; k++) frame_tick(1'b0);
        set_px(10'd220, 10'd120, 1'b1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        hold3(10'd220, 10'd120);
        for (int k = 10; k <= 44; k++) begin
            if (k > 10) frame_tick(1'b0);
            r     = k - 10;
            exp_f = (r < 32);
            exp_c = (exp_f && ((r / 4) % 2 == 0)) ? 12'hFFF : 12'h123;
            total++;
            if (rgb_s !== exp_c) begin
                bad++;
                $display("FAIL restart_rgb[frame %0d]: got %h want %h", k, rgb_s, exp_c);
            end
            total++;
            if (flashing !== exp_f) begin
                bad++;
                $display("FAIL restart_active[frame %0d]: got %b want %b", k, flashing, exp_f);
            end
        end
    endtask

    task automatic test_hit_on_tick();
        logic [11:0] exp_c;
        set_px(10'd220, 10'd120, 1'b1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        hold3(10'd220, 10'd120);
        frame_tick(1'b0);
        frame_tick(1'b0);
        frame_tick(1'b1);
        for (int n = 0; n <= 4; n++) begin
            if (n > 0) frame_tick(1'b0);
            exp_c = (n < 4) ? 12'hFFF : 12'h123;
            total++;
            if (rgb_s !== exp_c) begin
                bad++;
                $display("FAIL hit_on_tick[%0d]: got %h want %h", n, rgb_s, exp_c);
            end
        end
    endtask

    task automatic test_reset_mid_flash();
        logic [11:0] exp_c;
        total++;
        if (flashing !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_active: got %b want 1", flashing);
        end
        set_px(10'd220, 10'd120, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        total++;
        if (flashing !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_active: got %b want 0", flashing);
        end
        for (int n = 0; n < 4; n++) begin
            if (n > 0) tick();
            exp_c = (n < 3) ? 12'h000 : 12'h123;
            total++;
            if (rgb_s !== exp_c) begin
                bad++;
                $display("FAIL mid_reset_rgb[%0d]: got %h want %h", n, rgb_s, exp_c);
            end
            total++;
            if (blank_out !== (n >= 3)) begin
                bad++;
                $display("FAIL mid_reset_blank_out[%0d]: got %b want %b", n, blank_out, (n >= 3));
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        Reset      = 1'b1;
        DrawX      = 10'd220;
        DrawY      = 10'd120;
        blank      = 1'b1;
        pos_select = 1'b0;
        fig_enable = 1'b1;
        hit        = 1'b0;
        fig_color  = 12'h123;
        bg_color   = 12'h0F0;
        test_reset();
        test_region();
        test_transparency();
        test_blanking();
        test_anchor();
        test_flash();
        test_restart();
        test_hit_on_tick();
        test_reset_mid_flash();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_mixer.md
Name: layer_mixer

Overview:
- Pixel-domain compositor directly downstream of the figure sprite layer. Consumes the figure layer's 12-bit color and a background layer color.
- Aligns the figure-region test with the layer's fixed read latency and applies color-key transparency.
- Adds a frame-counted hit-flash effect and drives registered, blank-gated 4-bit R/G/B to the VGA output.

Parameters:
- LAYER_LAT, 2, pixel-clock latency from DrawX/DrawY to valid layer color (ROM register plus output register).
- KEY_COLOR, 12'hFDD, figure color treated as transparent (palette index 0).
- FLASH_FRAMES, 32, frames a flash lasts after a hit.
- FLASH_HALF, 4, frames per flash on/off half-period.

Ports:
- pixel_clk  in  1  pixel clock; all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video, 0 = blanking (undelayed).
- pos_select  in  1  figure vertical anchor: 1 = FIG_Y_START_F, 0 = FIG_Y_START_H. Must be the same value driven to the figure layer.
- fig_enable  in  1  1 = figure drawn.
- hit  in  1  single-cycle pulse; starts or restarts a flash.
- fig_color  in  12  figure layer color, valid LAYER_LAT cycles after DrawX/DrawY.
- bg_color  in  12  background layer color, same latency.
- Red, Green, Blue  out  4 each  final pixel color.
- blank_out  out  1  blank delayed to match Red/Green/Blue.
- flashing  out  1  flash effect active.

Behaviour:
- Reset: Red/Green/Blue = 0, blank_out = 0, flashing = 0, frame and flash counters = 0, all delay-line stages = 0.
- Region test, stage 0 (combinational). in_fig is true when all of the following hold:
  - fig_enable = 1;
  - FIG_X_START <= DrawX < FIG_X_START + FIG_X_SIZE;
  - anchorY <= DrawY < anchorY + FIG_Y_SIZE, where anchorY is selected by pos_select.
- Region arithmetic: compare in 11 bits so the upper bound cannot wrap.
- Delay line: in_fig and blank pass through a LAYER_LAT-deep shift register, aligning them with fig_color and bg_color.
- Output stage, one register after alignment. Total latency DrawX/DrawY -> Red/Green/Blue = LAYER_LAT + 1 = 3 cycles.
- Pixel selection, in priority order:
  - aligned blank = 0 -> output 12'h000;
  - else aligned in_fig = 1 and fig_color != KEY_COLOR -> use the figure pixel. If flash_on, output 12'hFFF; otherwise output fig_color;
  - else -> bg_color.
- blank_out is the aligned blank, registered in the same cycle as the color.
- Frame tick: one-cycle pulse when DrawX = 0 and DrawY = 0 at stage 0. Exactly one tick per frame.
- Flash state machine, states IDLE and FLASH:
  - IDLE -> FLASH on hit. flash_cnt := FLASH_FRAMES and phase_cnt := 0 on the next edge.
  - In FLASH, each frame tick:
    - flash_cnt decrements;
    - phase_cnt counts 0..FLASH_HALF-1 and wraps;
    - flash_on toggles each time phase_cnt wraps.
  - flash_on starts at 1 on entry.
  - FLASH -> IDLE when a tick decrements flash_cnt 1 -> 0. flash_on is cleared at the same edge.
  - flashing = (state == FLASH), registered.
- Simultaneous events:
  - hit during FLASH restarts the flash (counts reloaded, flash_on = 1).
  - hit on the same cycle as a frame tick: reload wins and the tick is ignored.
- Changing pos_select mid-frame takes effect on the next pixel. The delay line keeps alignment, so there is no tearing beyond the layer itself.
- Reset mid-flash returns to IDLE immediately and clears the pipeline. The first 3 output cycles after reset are black.

Decomposition:
- FIG_X_START, FIG_X_SIZE, FIG_Y_START_F, FIG_Y_START_H and FIG_Y_SIZE already live in utils.sv.
- Add KEY_COLOR_FIG and the flash constants there as defines, so other layers share them.
- One natural sub-module, delay_line (parameterised WIDTH, DEPTH, synchronous reset). It is used for the in_fig+blank vector.

Test Plan:
- Region alignment, pos_select = 0, fig_enable = 1:
  - stimulus: sweep DrawX across FIG_X_START-1 .. FIG_X_START at row FIG_Y_START_H; fig_color = 12'h123, bg_color = 12'h0F0.
  - required: output 12'h0F0, then 12'h123, each appearing exactly 3 cycles after the corresponding DrawX.
- Transparency:
  - stimulus: inside the region with fig_color = 12'hFDD, bg_color = 12'h00F.
  - required: output 12'h00F.
- Blanking:
  - stimulus: blank = 0 with any colors.
  - required: Red/Green/Blue = 0 and blank_out = 0, both 3 cycles later.
- Vertical anchor:
  - stimulus: pos_select = 1 at row FIG_Y_START_H (outside the F range), fig_color = 12'h123.
  - required: bg_color shown; at row FIG_Y_START_F the figure color is shown.
- Flash:
  - stimulus: pulse hit, then run 40 frame ticks with an opaque fig_color = 12'h123.
  - required: frames 0-3 give 12'hFFF, frames 4-7 give 12'h123, alternating; flashing drops after the 32nd tick; restart on a hit at frame 10 extends to frame 42.
- Reset:
  - stimulus: assert Reset mid-flash for 1 cycle.
  - required: flashing = 0, outputs 0 for 3 cycles, then normal compositing.
